// File: rtl/cntry_car_detector.sv
// Country-road vehicle detector: synchronises and debounces the loop sensor,
// latches calls to the signal controller and counts vehicles served on green.
module cntry_car_detector #(
  parameter int DEBOUNCE = 4,
  parameter int GAP      = 3,
  parameter int LOCK     = 1,
  parameter int CW       = 4
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          loop_raw,
  input  logic [1:0]    cntry_sig,
  output logic          car_on_cntry_rd,
  output logic          det,
  output logic [CW-1:0] served_count
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int GW  = $clog2(GAP + 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP);
  localparam logic [1:0]     SIG_GREEN = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALL  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  logic           s1_q, s1_d, s2_q, s2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           det_q, det_d, det_prev_q, det_prev_d;
  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           req_q, req_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           green, rise, fall;

  always_comb begin
    s1_d       = loop_raw;
    s2_d       = s1_q;
    db_cnt_d   = '0;
    det_d      = det_q;
    det_prev_d = det_q;
    if (s2_q != det_q) begin
      if (db_cnt_q == DB_LAST) det_d = s2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Edge events compare the current debounced level with its value one edge earlier
  assign green = (cntry_sig == SIG_GREEN);
  assign rise  = det_q & ~det_prev_q;
  assign fall  = ~det_q & det_prev_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (det_q) state_d = green ? ST_SERVE : ST_CALL;
      end
      ST_CALL: begin
        if (green)                      state_d = ST_SERVE;
        else if ((LOCK == 0) && !det_q) state_d = ST_IDLE;
      end
      ST_SERVE: begin
        if (fall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (!green) begin
          state_d = det_q ? ST_CALL : ST_IDLE;
          gap_d   = '0;
        end else if (fall) begin
          gap_d = GAP_LOAD;
        end else if (rise) begin
          gap_d = '0;
        end else if (!det_q && (gap_q != '0)) begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Request is derived from the next state so it moves in the same update
  always_comb begin
    case (state_d)
      ST_CALL:  req_d = 1'b1;
      ST_SERVE: req_d = det_q | (gap_d != '0);
      default:  req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_cnt_q   <= '0;
      det_q      <= 1'b0;
      det_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      req_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      db_cnt_q   <= db_cnt_d;
      det_q      <= det_d;
      det_prev_q <= det_prev_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
    end
  end

  assign car_on_cntry_rd = req_q;
  assign det             = det_q;
  assign served_count    = cnt_q;

endmodule

// File: tb/tb_cntry_car_detector.sv
// Bench for cntry_car_detector: three instances (locking, non-locking, 2-bit count)
// driven in parallel and compared every cycle against a behavioural model.
module tb_cntry_car_detector;

  localparam int D = 4;
  localparam int G = 3;
  localparam int M_IDLE  = 0;
  localparam int M_CALL  = 1;
  localparam int M_SERVE = 2;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       loop_raw = 1'b0;
  logic [1:0] cntry_sig = 2'd0;
  logic       req0, req1, req2, det0, det1, det2;
  logic [3:0] sc0, sc1;
  logic [1:0] sc2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          s1;
    bit          s2;
    bit          det;
    bit          chg;
    int unsigned hist;
    int          st;
    int          gap;
    bit          req;
    int          cnt;
  } mdl_t;

  mdl_t m [3];
  int   lock_p [3] = '{1, 0, 1};
  int   max_p  [3] = '{15, 15, 3};
  int   sat_exp [5] = '{1, 2, 3, 3, 3};

  always #5 clock = ~clock;

  cntry_car_detector #(.DEBOUNCE(D), .GAP(G), .LOCK(1), .CW(4)) u_dut (
    .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry_sig(cntry_sig),
    .car_on_cntry_rd(req0), .det(det0), .served_count(sc0));

  cntry_car_detector #(.DEBOUNCE(D), .GAP(G), .LOCK(0), .CW(4)) u_nolock (
    .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry_sig(cntry_sig),
    .car_on_cntry_rd(req1), .det(det1), .served_count(sc1));

  cntry_car_detector #(.DEBOUNCE(D), .GAP(G), .LOCK(1), .CW(2)) u_sat (
    .clock(clock), .clear(clear), .loop_raw(loop_raw), .cntry_sig(cntry_sig),
    .car_on_cntry_rd(req2), .det(det2), .served_count(sc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presence changes once the last D synchronised samples all disagree with it
  task automatic model_edge(input int i, input bit clr, input bit raw, input bit [1:0] sig);
    mdl_t        c;
    mdl_t        n;
    bit          green, fall, rise, flip;
    int unsigned mask, h;
    c = m[i];
    n = c;
    mask = (32'd1 << D) - 32'd1;
    if (clr) begin
      n.s1 = 0; n.s2 = 0; n.det = 0; n.chg = 0; n.hist = 0;
      n.st = M_IDLE; n.gap = 0; n.req = 0; n.cnt = 0;
    end else begin
      green = (sig == 2'd2);
      fall  = c.chg && !c.det;
      rise  = c.chg && c.det;
      if (c.st == M_IDLE) begin
        if (c.det) n.st = green ? M_SERVE : M_CALL;
      end else if (c.st == M_CALL) begin
        if (green) n.st = M_SERVE;
        else if (lock_p[i] == 0 && !c.det) n.st = M_IDLE;
      end else begin
        if (fall) n.cnt = (c.cnt + 1 > max_p[i]) ? max_p[i] : c.cnt + 1;
        if (!green) begin
          n.st  = c.det ? M_CALL : M_IDLE;
          n.gap = 0;
        end else if (fall) n.gap = G;
        else if (rise) n.gap = 0;
        else if (!c.det && c.gap > 0) n.gap = c.gap - 1;
      end
      n.req = (n.st == M_CALL) || (n.st == M_SERVE && (c.det || n.gap > 0));
      h      = (c.hist << 1) | 32'(c.s2);
      flip   = ((h & mask) == (c.det ? 32'd0 : mask));
      n.hist = h;
      n.det  = flip ? c.s2 : c.det;
      n.chg  = flip;
      n.s2   = c.s1;
      n.s1   = raw;
    end
    m[i] = n;
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_edge(i, clear, loop_raw, cntry_sig);
    #1;
    chk($sformatf("%s req0", tag), 32'(req0), 32'(m[0].req));
    chk($sformatf("%s det0", tag), 32'(det0), 32'(m[0].det));
    chk($sformatf("%s cnt0", tag), 32'(sc0),  32'(m[0].cnt));
    chk($sformatf("%s req1", tag), 32'(req1), 32'(m[1].req));
    chk($sformatf("%s det1", tag), 32'(det1), 32'(m[1].det));
    chk($sformatf("%s cnt1", tag), 32'(sc1),  32'(m[1].cnt));
    chk($sformatf("%s req2", tag), 32'(req2), 32'(m[2].req));
    chk($sformatf("%s det2", tag), 32'(det2), 32'(m[2].det));
    chk($sformatf("%s cnt2", tag), 32'(sc2),  32'(m[2].cnt));
  endtask

  initial begin
    int hold;

    clear = 1'b1; loop_raw = 1'b1; cntry_sig = 2'd0;
    repeat (5) step("reset");
    chk("reset_req", 32'(req0), 32'd0);
    chk("reset_det", 32'(det0), 32'd0);
    chk("reset_cnt", 32'(sc0), 32'd0);

    clear = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step("release");
      if (k == 5) chk("release_det_early", 32'(det0), 32'd0);
      if (k == 6) begin
        chk("release_det", 32'(det0), 32'd1);
        chk("release_req_early", 32'(req0), 32'd0);
      end
      if (k == 7) chk("release_req", 32'(req0), 32'd1);
    end

    loop_raw = 1'b0; clear = 1'b1;
    step("clr2");
    clear = 1'b0;
    repeat (4) step("idle");
    loop_raw = 1'b1;
    repeat (3) step("glitch3");
    loop_raw = 1'b0;
    repeat (8) step("glitch3_after");
    chk("glitch_det", 32'(det0), 32'd0);
    chk("glitch_req", 32'(req0), 32'd0);

    loop_raw = 1'b1;
    repeat (4) step("pulse4");
    loop_raw = 1'b0;
    repeat (3) step("pulse4_after");
    chk("pulse_det", 32'(det0), 32'd1);
    chk("pulse_req", 32'(req0), 32'd1);
    repeat (6) step("pulse4_drop");
    chk("lock_det", 32'(det0), 32'd0);
    chk("lock_req", 32'(req0), 32'd1);
    chk("nolock_req", 32'(req1), 32'd0);
    chk("nolock_cnt", 32'(sc1), 32'd0);

    loop_raw = 1'b1;
    repeat (8) step("serve_arrive");
    cntry_sig = 2'd2;
    repeat (2) step("serve_green");
    chk("serve_req", 32'(req0), 32'd1);
    loop_raw = 1'b0;
    repeat (6) step("serve_drop");
    chk("serve_cnt_before", 32'(sc0), 32'd0);
    step("serve_fall");
    chk("serve_cnt", 32'(sc0), 32'd1);
    chk("serve_gap_req", 32'(req0), 32'd1);
    repeat (2) step("serve_gap");
    chk("serve_gap_end", 32'(req0), 32'd1);
    step("serve_gap_over");
    chk("serve_req_off", 32'(req0), 32'd0);
    cntry_sig = 2'd0;
    repeat (2) step("serve_red");

    clear = 1'b1;
    step("sat_clr");
    clear = 1'b0;
    cntry_sig = 2'd2;
    for (int v = 0; v < 5; v++) begin
      loop_raw = 1'b1;
      repeat (8) step("sat_on");
      loop_raw = 1'b0;
      repeat (7) step("sat_off");
      chk($sformatf("sat_cnt%0d", v), 32'(sc2), 32'(sat_exp[v]));
    end

    loop_raw = 1'b1;
    repeat (8) step("mid_on");
    loop_raw = 1'b0;
    repeat (7) step("mid_gap");
    clear = 1'b1;
    step("mid_clear");
    chk("mid_req", 32'(req0), 32'd0);
    chk("mid_cnt0", 32'(sc0), 32'd0);
    chk("mid_cnt2", 32'(sc2), 32'd0);
    clear = 1'b0;
    cntry_sig = 2'd0;
    repeat (2) step("mid_after");

    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        loop_raw = ~loop_raw;
        hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      hold--;
      if ($urandom_range(0, 11) == 0)
        cntry_sig = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 249) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
